// File: rtl/rsa256_stream_ctrl.sv
// Byte-stream front end for the 256-bit modexp core: loads n, d and a
// (MSB first), starts the core, then streams the low TX_BYTES result bytes.
// Ports: i_rx_* byte input (valid/ready), o_tx_* byte output (valid/ready),
// o_core_* / i_core_* core interface, i_key_reload, o_key_loaded status.
module rsa256_stream_ctrl #(
  parameter int KEY_BYTES = 32,
  parameter int TX_BYTES  = 31
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [7:0]   i_rx_data,
  input  logic         i_rx_valid,
  output logic         o_rx_ready,
  output logic [7:0]   o_tx_data,
  output logic         o_tx_valid,
  input  logic         i_tx_ready,
  input  logic         i_key_reload,
  output logic         o_core_start,
  output logic [255:0] o_core_a,
  output logic [255:0] o_core_d,
  output logic [255:0] o_core_n,
  input  logic [255:0] i_core_a_pow_d,
  input  logic         i_core_finished,
  output logic         o_key_loaded
);

  typedef enum logic [2:0] {
    S_GET_N,
    S_GET_D,
    S_GET_A,
    S_START,
    S_WAIT,
    S_SEND
  } state_t;

  localparam logic [5:0] KEY_LAST = 6'(KEY_BYTES - 1);
  localparam logic [5:0] TX_LAST  = 6'(TX_BYTES - 1);

  state_t       state_q, state_d;
  logic [5:0]   cnt_q, cnt_d;
  logic [255:0] n_q, n_d;
  logic [255:0] d_q, d_d;
  logic [255:0] a_q, a_d;
  logic [255:0] tx_q, tx_d;
  logic         rx_ready_q, rx_ready_d;
  logic         tx_valid_q, tx_valid_d;
  logic         start_q, start_d;
  logic         key_loaded_q, key_loaded_d;

  logic rx_fire;
  logic tx_fire;

  assign rx_fire = i_rx_valid & rx_ready_q;
  assign tx_fire = tx_valid_q & i_tx_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    n_d          = n_q;
    d_d          = d_q;
    a_d          = a_q;
    tx_d         = tx_q;
    key_loaded_d = key_loaded_q;

    unique case (state_q)
      S_GET_N: begin
        if (rx_fire) begin
          n_d = {n_q[247:0], i_rx_data};
          if (cnt_q == KEY_LAST) begin
            cnt_d   = '0;
            state_d = S_GET_D;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      S_GET_D: begin
        if (rx_fire) begin
          d_d = {d_q[247:0], i_rx_data};
          if (cnt_q == KEY_LAST) begin
            cnt_d        = '0;
            key_loaded_d = 1'b1;
            state_d      = S_GET_A;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      S_GET_A: begin
        if (rx_fire) begin
          a_d = {a_q[247:0], i_rx_data};
          if (cnt_q == KEY_LAST) begin
            cnt_d   = '0;
            state_d = S_START;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end else if (i_key_reload && (cnt_q == '0)) begin
          // Reload only between blocks so a half-received a is never mixed
          // with a new key.
          key_loaded_d = 1'b0;
          state_d      = S_GET_N;
        end
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_core_finished) begin
          tx_d    = i_core_a_pow_d;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (tx_fire) begin
          tx_d = tx_q << 8;
          if (cnt_q == TX_LAST) begin
            cnt_d   = '0;
            state_d = S_GET_A;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      default: begin
        state_d = S_GET_N;
        cnt_d   = '0;
      end
    endcase

    // Handshake outputs are registered and decoded from the next state,
    // so they line up with the state they describe.
    rx_ready_d = (state_d == S_GET_N) || (state_d == S_GET_D) ||
                 (state_d == S_GET_A);
    tx_valid_d = (state_d == S_SEND);
    start_d    = (state_d == S_START);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_GET_N;
      cnt_q        <= '0;
      n_q          <= '0;
      d_q          <= '0;
      a_q          <= '0;
      tx_q         <= '0;
      rx_ready_q   <= 1'b0;
      tx_valid_q   <= 1'b0;
      start_q      <= 1'b0;
      key_loaded_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      n_q          <= n_d;
      d_q          <= d_d;
      a_q          <= a_d;
      tx_q         <= tx_d;
      rx_ready_q   <= rx_ready_d;
      tx_valid_q   <= tx_valid_d;
      start_q      <= start_d;
      key_loaded_q <= key_loaded_d;
    end
  end

  assign o_rx_ready   = rx_ready_q;
  assign o_tx_valid   = tx_valid_q;
  assign o_tx_data    = tx_q[TX_BYTES*8-1 -: 8];
  assign o_core_start = start_q;
  assign o_core_a     = a_q;
  assign o_core_d     = d_q;
  assign o_core_n     = n_q;
  assign o_key_loaded = key_loaded_q;

endmodule

// File: tb/tb_rsa256_stream_ctrl.sv
// Directed bench for rsa256_stream_ctrl with a behavioural modexp core
// (10-cycle latency) and per-scenario checking tasks.
module tb_rsa256_stream_ctrl;

  localparam int TXB = 31;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         o_rx_ready;
  logic [7:0]   o_tx_data;
  logic         o_tx_valid;
  logic         tx_ready;
  logic         key_reload;
  logic         o_core_start;
  logic [255:0] o_core_a;
  logic [255:0] o_core_d;
  logic [255:0] o_core_n;
  logic [255:0] core_res;
  logic         core_fin;
  logic         o_key_loaded;

  logic         fin_model = 1'b0;
  logic         fin_force;
  logic         busy = 1'b0;
  int           lat = 0;

  int tests = 0;
  int fails = 0;
  int rx_acc = 0;
  int tx_acc = 0;
  int start_cnt = 0;

  always #5 clk = ~clk;

  rsa256_stream_ctrl #(.KEY_BYTES(32), .TX_BYTES(TXB)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_rx_data      (rx_data),
    .i_rx_valid     (rx_valid),
    .o_rx_ready     (o_rx_ready),
    .o_tx_data      (o_tx_data),
    .o_tx_valid     (o_tx_valid),
    .i_tx_ready     (tx_ready),
    .i_key_reload   (key_reload),
    .o_core_start   (o_core_start),
    .o_core_a       (o_core_a),
    .o_core_d       (o_core_d),
    .o_core_n       (o_core_n),
    .i_core_a_pow_d (core_res),
    .i_core_finished(core_fin),
    .o_key_loaded   (o_key_loaded)
  );

  function automatic logic [255:0] modexp(input logic [255:0] a,
                                          input logic [255:0] d,
                                          input logic [255:0] n);
    logic [511:0] r;
    logic [511:0] b;
    logic [511:0] m;
    if (n == 0) return '0;
    m = {256'd0, n};
    r = 512'd1 % m;
    b = {256'd0, a} % m;
    for (int i = 0; i < 256; i++) begin
      if (d[i]) r = (r * b) % m;
      b = (b * b) % m;
    end
    return r[255:0];
  endfunction

  // Core model ignores i_rst on purpose so an abandoned run still
  // delivers a stale finished pulse.
  always @(posedge clk) begin
    fin_model <= 1'b0;
    if (busy) begin
      if (lat == 1) begin
        fin_model <= 1'b1;
        busy      <= 1'b0;
      end
      lat <= lat - 1;
    end
    if (o_core_start) begin
      busy     <= 1'b1;
      lat      <= 10;
      core_res <= modexp(o_core_a, o_core_d, o_core_n);
    end
  end

  assign core_fin = fin_model | fin_force;

  always @(posedge clk) begin
    if (rx_valid && o_rx_ready) rx_acc <= rx_acc + 1;
    if (o_tx_valid && tx_ready) tx_acc <= tx_acc + 1;
    if (o_core_start) start_cnt <= start_cnt + 1;
    if (o_rx_ready && o_tx_valid) begin
      fails <= fails + 1;
      $display("FAIL rx_tx_overlap: rx_ready=1 tx_valid=1 required not both");
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    while (!o_rx_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    tests++;
    if (t >= 200) begin
      fails++;
      $display("FAIL rx_timeout: rx_ready=%0b required 1", o_rx_ready);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_range(input logic [255:0] v, input int first,
                            input int last);
    for (int k = first; k <= last; k++)
      send_byte(v[(31-k)*8 +: 8]);
  endtask

  task automatic recv_block(input int mode, output logic [255:0] got);
    int cnt;
    int t;
    int stall;
    logic [7:0] held;
    logic hv;
    cnt = 0; t = 0; stall = 0; hv = 1'b0; held = '0;
    got = '0;
    while (cnt < TXB && t < 400) begin
      if (mode == 0) tx_ready = 1'b1;
      else if (cnt == 0 && stall < 5) begin
        tx_ready = 1'b0;
        stall++;
      end else tx_ready = 1'($urandom_range(0, 1));
      if (o_tx_valid) begin
        if (hv) begin
          tests++;
          if (o_tx_data !== held) begin
            fails++;
            $display("FAIL tx_hold: data=%h required %h", o_tx_data, held);
          end
        end
        if (tx_ready) begin
          got = {got[247:0], o_tx_data};
          cnt++;
          hv = 1'b0;
        end else begin
          held = o_tx_data;
          hv   = 1'b1;
        end
      end
      @(negedge clk);
      t++;
    end
    tx_ready = 1'b0;
    tests++;
    if (cnt != TXB) begin
      fails++;
      $display("FAIL tx_count: got %0d bytes required %0d", cnt, TXB);
    end
    tests++;
    if (o_rx_ready !== 1'b1 || o_tx_valid !== 1'b0) begin
      fails++;
      $display("FAIL tx_done_lat: rx_ready=%b tx_valid=%b required 1/0",
               o_rx_ready, o_tx_valid);
    end
  endtask

  task automatic load_key(input logic [255:0] n, input logic [255:0] d);
    send_range(n, 0, 31);
    send_range(d, 0, 31);
    tests++;
    if (o_key_loaded !== 1'b1) begin
      fails++;
      $display("FAIL key_loaded: got %b required 1", o_key_loaded);
    end
  endtask

  task automatic run_block(input logic [255:0] a, input int mode,
                           input logic [255:0] exp_res, input int hold_rx);
    logic [255:0] got;
    int s0;
    int r0;
    int t;
    s0 = start_cnt;
    send_range(a, 0, 31);
    tests++;
    if (o_core_start !== 1'b1 || o_rx_ready !== 1'b0) begin
      fails++;
      $display("FAIL start_lat: start=%b rx_ready=%b required 1/0",
               o_core_start, o_rx_ready);
    end
    tests++;
    if (o_core_a !== a) begin
      fails++;
      $display("FAIL core_a: got %h required %h", o_core_a, a);
    end
    if (hold_rx != 0) begin
      rx_valid = 1'b1;
      rx_data  = 8'hAA;
    end
    r0 = rx_acc;
    t = 0;
    while (!core_fin && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    tests++;
    if (o_tx_valid !== 1'b1) begin
      fails++;
      $display("FAIL fin_lat: tx_valid=%b required 1", o_tx_valid);
    end
    recv_block(mode, got);
    tests++;
    if (rx_acc != r0) begin
      fails++;
      $display("FAIL rx_blocked: accepted %0d required 0", rx_acc - r0);
    end
    rx_valid = 1'b0;
    tests++;
    if (got !== exp_res) begin
      fails++;
      $display("FAIL result: got %h required %h", got, exp_res);
    end
    tests++;
    if (start_cnt - s0 != 1) begin
      fails++;
      $display("FAIL start_pulses: got %0d required 1", start_cnt - s0);
    end
  endtask

  task automatic check_zero(input string nm);
    tests++;
    if (o_rx_ready !== 1'b0 || o_tx_valid !== 1'b0 ||
        o_core_start !== 1'b0 || o_key_loaded !== 1'b0 ||
        o_tx_data !== 8'h00 || o_core_n !== '0 ||
        o_core_d !== '0 || o_core_a !== '0) begin
      fails++;
      $display("FAIL %s: rdy=%b val=%b st=%b kl=%b txd=%h required all 0",
               nm, o_rx_ready, o_tx_valid, o_core_start, o_key_loaded,
               o_tx_data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_zero("reset_state");
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (o_rx_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %b required 1", o_rx_ready);
    end
  endtask

  task automatic test_basic();
    load_key(256'd7, 256'd9);
    run_block(256'd5, 0, 256'd6, 0);
  endtask

  task automatic test_back_to_back();
    run_block(256'd3, 0, 256'd6, 1);
    tests++;
    if (o_key_loaded !== 1'b1) begin
      fails++;
      $display("FAIL b2b_key: got %b required 1", o_key_loaded);
    end
  endtask

  task automatic test_tx_stall();
    run_block(256'd5, 1, 256'd6, 0);
  endtask

  task automatic test_spurious_finished();
    int t0;
    send_range(256'd4, 0, 9);
    t0 = tx_acc;
    tx_ready = 1'b1;
    fin_force = 1'b1;
    @(negedge clk);
    fin_force = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (o_tx_valid !== 1'b0 || o_rx_ready !== 1'b1) begin
        fails++;
        $display("FAIL spurious_fin: tx_valid=%b rx_ready=%b required 0/1",
                 o_tx_valid, o_rx_ready);
      end
      @(negedge clk);
    end
    tx_ready = 1'b0;
    tests++;
    if (tx_acc != t0) begin
      fails++;
      $display("FAIL spurious_tx: got %0d transfers required 0",
               tx_acc - t0);
    end
    send_range(256'd4, 10, 30);
    tests++;
    if (o_core_start !== 1'b0) begin
      fails++;
      $display("FAIL spurious_cnt: start=%b required 0", o_core_start);
    end
    run_tail_byte();
  endtask

  task automatic run_tail_byte();
    logic [255:0] got;
    send_byte(8'h04);
    tests++;
    if (o_core_start !== 1'b1) begin
      fails++;
      $display("FAIL spurious_start: start=%b required 1", o_core_start);
    end
    while (!o_tx_valid) @(negedge clk);
    recv_block(0, got);
    tests++;
    if (got !== 256'd1) begin
      fails++;
      $display("FAIL spurious_res: got %h required 1", got);
    end
  endtask

  task automatic test_key_reload();
    rx_valid   = 1'b0;
    key_reload = 1'b1;
    @(negedge clk);
    key_reload = 1'b0;
    tests++;
    if (o_key_loaded !== 1'b0 || o_rx_ready !== 1'b1) begin
      fails++;
      $display("FAIL reload_drop: key_loaded=%b rx_ready=%b required 0/1",
               o_key_loaded, o_rx_ready);
    end
    load_key(256'd11, 256'd3);
    run_block(256'd2, 0, 256'd8, 0);
  endtask

  task automatic test_reset_mid();
    int t0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send_range(256'd7, 0, 31);
    send_range(256'd9, 0, 16);
    rst = 1'b1;
    @(negedge clk);
    check_zero("reset_mid_d");
    rst = 1'b0;
    load_key(256'd7, 256'd9);
    send_range(256'd5, 0, 31);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero("reset_wait");
    rst = 1'b0;
    t0 = tx_acc;
    tx_ready = 1'b1;
    for (int i = 0; i < 15; i++) @(negedge clk);
    tx_ready = 1'b0;
    tests++;
    if (tx_acc != t0 || o_key_loaded !== 1'b0) begin
      fails++;
      $display("FAIL stale_fin: tx=%0d key_loaded=%b required 0/0",
               tx_acc - t0, o_key_loaded);
    end
    load_key(256'd7, 256'd9);
    run_block(256'd5, 0, 256'd6, 0);
  endtask

  initial begin
    rst        = 1'b1;
    rx_data    = '0;
    rx_valid   = 1'b0;
    tx_ready   = 1'b0;
    key_reload = 1'b0;
    fin_force  = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_tx_stall();
    test_spurious_finished();
    test_key_reload();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: sim time exceeded");
    $fatal(1, "timeout");
  end

endmodule
